// File: rtl/pkt_gap_meter.sv
// Pass-through pipeline stage that forwards words with one cycle of latency,
// delineates packets from ctrl and records SOP-to-SOP gap statistics.
module pkt_gap_meter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  stats_clear,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  last_gap,
    output logic [CNT_WIDTH-1:0]  min_gap,
    output logic [CNT_WIDTH-1:0]  max_gap,
    output logic                  gap_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOD_HDR = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  sop;
    logic                  ctrl_nz;
    logic [CNT_WIDTH-1:0]  timebase;
    logic [CNT_WIDTH-1:0]  last_sop;
    logic                  have_ref;
    logic [CNT_WIDTH-1:0]  gap;

    // Upstream is only allowed to write while downstream can take the word,
    // so the stage never needs to buffer or stall.
    assign in_rdy  = out_rdy;
    assign ctrl_nz = (in_ctrl != '0);
    assign gap     = timebase - last_sop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_ctrl <= '0;
            out_wr   <= 1'b0;
        end else begin
            out_wr <= in_wr;
            if (in_wr) begin
                out_data <= in_data;
                out_ctrl <= in_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timebase <= '0;
        end else begin
            timebase <= timebase + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sop        = 1'b0;
        if (in_wr) begin
            case (state)
                IDLE: begin
                    if (ctrl_nz) begin
                        state_next = MOD_HDR;
                        sop        = 1'b1;
                    end
                end
                MOD_HDR: begin
                    if (!ctrl_nz) state_next = PAYLOAD;
                end
                PAYLOAD: begin
                    if (ctrl_nz) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A clear that lands on an SOP wins, but that SOP still becomes the
    // reference point and the first counted packet of the new epoch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
            last_gap  <= '0;
            min_gap   <= '1;
            max_gap   <= '0;
            gap_valid <= 1'b0;
            last_sop  <= '0;
            have_ref  <= 1'b0;
        end else if (stats_clear) begin
            last_gap  <= '0;
            min_gap   <= '1;
            max_gap   <= '0;
            gap_valid <= 1'b0;
            if (sop) begin
                pkt_count <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                last_sop  <= timebase;
                have_ref  <= 1'b1;
            end else begin
                pkt_count <= '0;
                last_sop  <= '0;
                have_ref  <= 1'b0;
            end
        end else if (sop) begin
            if (pkt_count != '1) pkt_count <= pkt_count + 1'b1;
            if (have_ref) begin
                last_gap  <= gap;
                gap_valid <= 1'b1;
                if (gap < min_gap) min_gap <= gap;
                if (gap > max_gap) max_gap <= gap;
            end
            last_sop <= timebase;
            have_ref <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pkt_gap_meter.sv
// Directed bench for pkt_gap_meter: forwarding, gap statistics, clear
// collision, timebase wrap with backpressure, and asynchronous reset.
module tb_pkt_gap_meter;

    logic        clk;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        stats_clear;
    logic [31:0] pkt_count, last_gap, min_gap, max_gap;
    logic        gap_valid;

    // Narrow-timebase instance fed with the same stream, used to reach wrap.
    logic        w_in_rdy;
    logic [63:0] w_out_data;
    logic [7:0]  w_out_ctrl;
    logic        w_out_wr;
    logic [7:0]  w_pkt_count, w_last_gap, w_min_gap, w_max_gap;
    logic        w_gap_valid;

    int          total = 0;
    int          bad   = 0;
    int          wr_seen = 0;
    logic [31:0] tb_time;

    pkt_gap_meter dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_wr(in_wr), .in_rdy(in_rdy), .out_data(out_data),
        .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .stats_clear(stats_clear), .pkt_count(pkt_count),
        .last_gap(last_gap), .min_gap(min_gap), .max_gap(max_gap),
        .gap_valid(gap_valid)
    );

    pkt_gap_meter #(.CNT_WIDTH(8)) dut_w (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_wr(in_wr), .in_rdy(w_in_rdy), .out_data(w_out_data),
        .out_ctrl(w_out_ctrl), .out_wr(w_out_wr), .out_rdy(out_rdy),
        .stats_clear(stats_clear), .pkt_count(w_pkt_count),
        .last_gap(w_last_gap), .min_gap(w_min_gap), .max_gap(w_max_gap),
        .gap_valid(w_gap_valid)
    );

    // Clock/reset block and a reference timebase kept by the bench.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) tb_time <= '0;
        else       tb_time <= tb_time + 32'd1;
    end

    always @(negedge clk) begin
        if (out_wr === 1'b1) wr_seen++;
    end

    // Driver: presents one word, returns #1 after the accepting edge.
    task automatic drive(input logic [63:0] d, input logic [7:0] c, input logic clr);
        in_data = d; in_ctrl = c; in_wr = 1'b1; stats_clear = clr;
        @(posedge clk); #1;
        in_wr = 1'b0; stats_clear = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_until(input logic [31:0] target, input logic [31:0] mask);
        int n;
        n = 0;
        while (((tb_time & mask) != target) && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 4000) begin
            $display("FAIL wait_timebase got=%h exp=%h", tb_time & mask, target);
            bad++;
        end
    endtask

    task automatic send_pkt(input logic [31:0] start, input logic clr_on_sop);
        wait_until(start, 32'hFFFF_FFFF);
        drive(64'hA0, 8'hFF, clr_on_sop);
        drive(64'hA1, 8'h00, 1'b0);
        drive(64'hA2, 8'h00, 1'b0);
        drive(64'hA3, 8'h0F, 1'b0);
    endtask

    task automatic pulse_clear();
        stats_clear = 1'b1;
        @(posedge clk); #1;
        stats_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_data = '0; in_ctrl = '0; in_wr = 1'b0;
        out_rdy = 1'b1; stats_clear = 1'b0;
        idle_cycles(3);
        total++; if (out_wr !== 1'b0) begin $display("FAIL rst_out_wr got=%b exp=0", out_wr); bad++; end
        total++; if (out_data !== 64'd0) begin $display("FAIL rst_out_data got=%h exp=0", out_data); bad++; end
        total++; if (pkt_count !== 32'd0) begin $display("FAIL rst_pkt_count got=%h exp=0", pkt_count); bad++; end
        total++; if (min_gap !== 32'hFFFF_FFFF) begin $display("FAIL rst_min_gap got=%h exp=ffffffff", min_gap); bad++; end
        total++; if (max_gap !== 32'd0 || last_gap !== 32'd0 || gap_valid !== 1'b0) begin
            $display("FAIL rst_gaps got=%h/%h/%b exp=0/0/0", max_gap, last_gap, gap_valid); bad++; end
        out_rdy = 1'b0; #1;
        total++; if (in_rdy !== 1'b0) begin $display("FAIL rdy_low got=%b exp=0", in_rdy); bad++; end
        out_rdy = 1'b1; #1;
        total++; if (in_rdy !== 1'b1) begin $display("FAIL rdy_high got=%b exp=1", in_rdy); bad++; end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_forwarding();
        logic [7:0] ctrls [4];
        int wr_before;
        ctrls[0] = 8'hFF; ctrls[1] = 8'h00; ctrls[2] = 8'h00; ctrls[3] = 8'h0F;
        wr_before = wr_seen;
        for (int i = 0; i < 4; i++) begin
            drive(64'(i + 1), ctrls[i], 1'b0);
            total++; if (out_wr !== 1'b1 || out_data !== 64'(i + 1) || out_ctrl !== ctrls[i]) begin
                $display("FAIL fwd_word%0d got=%b/%h/%h exp=1/%h/%h", i, out_wr, out_data, out_ctrl, i + 1, ctrls[i]); bad++; end
        end
        idle_cycles(2);
        total++; if (out_wr !== 1'b0 || out_data !== 64'd4 || out_ctrl !== 8'h0F) begin
            $display("FAIL fwd_hold got=%b/%h/%h exp=0/4/0f", out_wr, out_data, out_ctrl); bad++; end
        total++; if (wr_seen - wr_before !== 4) begin
            $display("FAIL fwd_wr_count got=%0d exp=4", wr_seen - wr_before); bad++; end
        total++; if (w_out_wr !== 1'b0 || w_out_data !== 64'd4 || w_out_ctrl !== 8'h0F) begin
            $display("FAIL fwd_narrow got=%b/%h/%h exp=0/4/0f", w_out_wr, w_out_data, w_out_ctrl); bad++; end
        // One packet after reset: counted, but no gap yet.
        total++; if (pkt_count !== 32'd1 || gap_valid !== 1'b0) begin
            $display("FAIL first_pkt got=%h/%b exp=1/0", pkt_count, gap_valid); bad++; end
        total++; if (min_gap !== 32'hFFFF_FFFF || max_gap !== 32'd0 || last_gap !== 32'd0) begin
            $display("FAIL first_gaps got=%h/%h/%h exp=ffffffff/0/0", min_gap, max_gap, last_gap); bad++; end
    endtask

    task automatic test_gap();
        pulse_clear();
        total++; if (pkt_count !== 32'd0) begin $display("FAIL clr_pkt got=%h exp=0", pkt_count); bad++; end
        send_pkt(32'd100, 1'b0);
        send_pkt(32'd150, 1'b0);
        send_pkt(32'd400, 1'b0);
        idle_cycles(2);
        total++; if (pkt_count !== 32'd3) begin $display("FAIL gap_pkt got=%h exp=3", pkt_count); bad++; end
        total++; if (last_gap !== 32'd250) begin $display("FAIL gap_last got=%0d exp=250", last_gap); bad++; end
        total++; if (min_gap !== 32'd50) begin $display("FAIL gap_min got=%0d exp=50", min_gap); bad++; end
        total++; if (max_gap !== 32'd250) begin $display("FAIL gap_max got=%0d exp=250", max_gap); bad++; end
        total++; if (gap_valid !== 1'b1) begin $display("FAIL gap_valid got=%b exp=1", gap_valid); bad++; end
    endtask

    task automatic test_clear_collision();
        pulse_clear();
        send_pkt(32'd500, 1'b0);
        send_pkt(32'd530, 1'b0);
        send_pkt(32'd560, 1'b1);
        idle_cycles(1);
        total++; if (pkt_count !== 32'd1 || gap_valid !== 1'b0) begin
            $display("FAIL coll_pkt got=%h/%b exp=1/0", pkt_count, gap_valid); bad++; end
        total++; if (min_gap !== 32'hFFFF_FFFF || max_gap !== 32'd0) begin
            $display("FAIL coll_gaps got=%h/%h exp=ffffffff/0", min_gap, max_gap); bad++; end
        send_pkt(32'd580, 1'b0);
        idle_cycles(1);
        total++; if (last_gap !== 32'd20 || min_gap !== 32'd20 || max_gap !== 32'd20) begin
            $display("FAIL coll_next got=%0d/%0d/%0d exp=20/20/20", last_gap, min_gap, max_gap); bad++; end
        total++; if (pkt_count !== 32'd2 || gap_valid !== 1'b1) begin
            $display("FAIL coll_next_pkt got=%h/%b exp=2/1", pkt_count, gap_valid); bad++; end
    endtask

    task automatic test_wrap_backpressure();
        int wr_before;
        pulse_clear();
        wr_before = wr_seen;
        wait_until(32'h0000_00F0, 32'h0000_00FF);
        drive(64'hB0, 8'hFF, 1'b0);
        drive(64'hB1, 8'h00, 1'b0);
        drive(64'hB2, 8'h0F, 1'b0);
        out_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++; if (in_rdy !== 1'b0 || w_in_rdy !== 1'b0 || out_wr !== 1'b0) begin
                $display("FAIL bp_cycle%0d got=%b/%b/%b exp=0/0/0", i, in_rdy, w_in_rdy, out_wr); bad++; end
        end
        out_rdy = 1'b1; #1;
        total++; if (in_rdy !== 1'b1) begin $display("FAIL bp_release got=%b exp=1", in_rdy); bad++; end
        wait_until(32'h0000_0010, 32'h0000_00FF);
        drive(64'hC0, 8'hFF, 1'b0);
        drive(64'hC1, 8'h00, 1'b0);
        drive(64'hC2, 8'h0F, 1'b0);
        idle_cycles(2);
        total++; if (w_last_gap !== 8'h20 || w_min_gap !== 8'h20 || w_max_gap !== 8'h20) begin
            $display("FAIL wrap_gap got=%h/%h/%h exp=20/20/20", w_last_gap, w_min_gap, w_max_gap); bad++; end
        total++; if (w_pkt_count !== 8'd2 || w_gap_valid !== 1'b1) begin
            $display("FAIL wrap_pkt got=%h/%b exp=2/1", w_pkt_count, w_gap_valid); bad++; end
        total++; if (last_gap !== 32'h20) begin $display("FAIL wide_gap got=%h exp=20", last_gap); bad++; end
        total++; if (wr_seen - wr_before !== 6) begin
            $display("FAIL bp_words got=%0d exp=6", wr_seen - wr_before); bad++; end
    endtask

    task automatic test_reset_mid_payload();
        drive(64'hD0, 8'hFF, 1'b0);
        drive(64'hD1, 8'h00, 1'b0);
        drive(64'hD2, 8'h00, 1'b0);
        #2 reset = 1'b1;
        #1;
        total++; if (out_wr !== 1'b0 || out_data !== 64'd0 || out_ctrl !== 8'd0) begin
            $display("FAIL arst_out got=%b/%h/%h exp=0/0/0", out_wr, out_data, out_ctrl); bad++; end
        total++; if (pkt_count !== 32'd0 || gap_valid !== 1'b0 || min_gap !== 32'hFFFF_FFFF) begin
            $display("FAIL arst_stats got=%h/%b/%h exp=0/0/ffffffff", pkt_count, gap_valid, min_gap); bad++; end
        @(posedge clk); #1;
        reset = 1'b0;
        drive(64'hE0, 8'h00, 1'b0);
        total++; if (out_wr !== 1'b1 || out_data !== 64'hE0) begin
            $display("FAIL stray_fwd got=%b/%h exp=1/e0", out_wr, out_data); bad++; end
        drive(64'hE1, 8'hFF, 1'b0);
        drive(64'hE2, 8'h00, 1'b0);
        drive(64'hE3, 8'h0F, 1'b0);
        idle_cycles(1);
        total++; if (pkt_count !== 32'd1 || gap_valid !== 1'b0) begin
            $display("FAIL post_rst_pkt got=%h/%b exp=1/0", pkt_count, gap_valid); bad++; end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_gap();
        test_clear_collision();
        test_wrap_backpressure();
        test_reset_mid_payload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
